// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: branch-predictor defaults, counter encodings and the
// per-entry record of the gshare target buffer.
package mips_pkg;

    localparam int BPB_PORTS  = 2;
    localparam int BPB_IDX_W  = 6;
    localparam int BPB_HIST_W = 4;
    localparam int BPB_TAG_W  = 8;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_STRONG_NT = 2'b00;
    localparam ctr2_t CTR_WEAK_NT   = 2'b01;
    localparam ctr2_t CTR_WEAK_T    = 2'b10;
    localparam ctr2_t CTR_STRONG_T  = 2'b11;

    // The tag field is BPB_TAG_W wide; a module TAG_W narrower than that is zero-extended.
    typedef struct packed {
        logic                 valid;
        logic [BPB_TAG_W-1:0] tag;
        logic [31:0]          target;
        ctr2_t                ctr;
    } bpb_entry_t;

endpackage

// File: rtl/bpb_ctr2.sv
// Next value of a 2-bit saturating direction counter for one commit: step on a tag hit,
// re-seed to the weak state matching the outcome on allocation.
module bpb_ctr2
    import mips_pkg::*;
(
    input  ctr2_t ctr_i,
    input  logic  match_i,
    input  logic  taken_i,
    output ctr2_t ctr_o
);

    // NOTE: default assignment first so every path drives ctr_o and no latch is inferred.
    always_comb begin
        ctr_o = ctr_i;
        if (!match_i) begin
            ctr_o = taken_i ? CTR_WEAK_T : CTR_WEAK_NT;
        end else if (taken_i) begin
            if (ctr_i != CTR_STRONG_T) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != CTR_STRONG_NT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/bpb_gshare.sv
// Multi-port gshare branch target buffer with a single commit/update port.
// Optional feature macro: BPB_SPEC_HIST_EN (speculative lookup history, repaired on mispredict).
module bpb_gshare
    import mips_pkg::*;
#(
    parameter int PORTS  = BPB_PORTS,
    parameter int IDX_W  = BPB_IDX_W,
    parameter int HIST_W = BPB_HIST_W,
    parameter int TAG_W  = BPB_TAG_W
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   stall,
    input  logic [PORTS-1:0][31:0] pc_predict,
    input  logic                   predict_valid,
    output logic [PORTS-1:0]       hit,
    output logic [PORTS-1:0]       taken,
    output logic [PORTS-1:0][31:0] target,
    input  logic                   wen,
    input  logic [31:0]            pc_commit,
    input  logic                   taken_commit,
    input  logic [31:0]            target_commit,
    input  logic                   mispredict
);

    localparam int ENTRIES = 2**IDX_W;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [HIST_W-1:0] hist_t;
    typedef logic [TAG_W-1:0]  tag_t;

    function automatic idx_t f_idx(input logic [31:0] pc, input hist_t h);
        return pc[IDX_W+1:2] ^ idx_t'(h);
    endfunction

    function automatic tag_t f_tag(input logic [31:0] pc);
        return pc[IDX_W+TAG_W+1:IDX_W+2];
    endfunction

    function automatic hist_t f_shift(input hist_t h, input logic b);
        return hist_t'({h, b});
    endfunction

    logic        valid_q [ENTRIES];
    ctr2_t       ctr_q   [ENTRIES];
    tag_t        tag_q   [ENTRIES];
    logic [31:0] tgt_q   [ENTRIES];

    hist_t ghist_q, ghist_d;
    hist_t look_hist;

    logic [PORTS-1:0]       hit_q, taken_q;
    logic [PORTS-1:0][31:0] target_q;
    logic [PORTS-1:0]       hit_d, taken_d;
    logic [PORTS-1:0][31:0] target_d;

    idx_t       look_idx [PORTS];
    bpb_entry_t rd_entry [PORTS];

    // Lookup reads the pre-commit table, so a same-cycle update is invisible to it.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            look_idx[p]        = f_idx(pc_predict[p], look_hist);
            rd_entry[p].valid  = valid_q[look_idx[p]];
            rd_entry[p].tag    = BPB_TAG_W'(tag_q[look_idx[p]]);
            rd_entry[p].target = tgt_q[look_idx[p]];
            rd_entry[p].ctr    = ctr_q[look_idx[p]];
            hit_d[p]    = rd_entry[p].valid && (rd_entry[p].tag == BPB_TAG_W'(f_tag(pc_predict[p])));
            taken_d[p]  = hit_d[p] && rd_entry[p].ctr[1];
            target_d[p] = rd_entry[p].target;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit_q    <= '0;
            taken_q  <= '0;
            target_q <= '0;
        end else if (!stall) begin
            if (predict_valid) begin
                hit_q    <= hit_d;
                taken_q  <= taken_d;
                target_q <= target_d;
            end else begin
                hit_q   <= '0;
                taken_q <= '0;
            end
        end
    end

    assign hit    = hit_q;
    assign taken  = taken_q;
    assign target = target_q;

    idx_t  cm_idx;
    tag_t  cm_tag;
    logic  cm_match;
    ctr2_t cm_ctr_d;

    assign cm_idx   = f_idx(pc_commit, ghist_q);
    assign cm_tag   = f_tag(pc_commit);
    assign cm_match = valid_q[cm_idx] && (tag_q[cm_idx] == cm_tag);
    assign ghist_d  = wen ? f_shift(ghist_q, taken_commit) : ghist_q;

    bpb_ctr2 u_ctr2 (
        .ctr_i   (ctr_q[cm_idx]),
        .match_i (cm_match),
        .taken_i (taken_commit),
        .ctr_o   (cm_ctr_d)
    );

    // NOTE: only valid and ctr need a reset value; tag/target sit in a no-reset array so they can map to plain storage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WEAK_NT;
            end
        end else if (wen) begin
            valid_q[cm_idx] <= 1'b1;
            ctr_q[cm_idx]   <= cm_ctr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wen) begin
            tag_q[cm_idx] <= cm_tag;
            tgt_q[cm_idx] <= target_commit;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ghist_q <= '0;
        else         ghist_q <= ghist_d;
    end

`ifdef BPB_SPEC_HIST_EN
    hist_t spec_hist_q, spec_hist_d;

    // The lowest port with hit&taken always contributes a 1, so the shifted bit is the OR of taken_d.
    always_comb begin
        spec_hist_d = spec_hist_q;
        if (wen && mispredict)
            spec_hist_d = ghist_d;
        else if (predict_valid && !stall)
            spec_hist_d = f_shift(spec_hist_q, |taken_d);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) spec_hist_q <= '0;
        else         spec_hist_q <= spec_hist_d;
    end

    assign look_hist = spec_hist_q;
`else
    assign look_hist = ghist_q;
`endif

    // Collects PC bits outside index/tag, the counter LSB and mispredict (unused without the speculative history).
    logic unused_ok;
    always_comb begin
        unused_ok = ^{pc_predict, pc_commit, mispredict};
        for (int p = 0; p < PORTS; p++) unused_ok = unused_ok ^ rd_entry[p].ctr[0];
    end

endmodule

// File: tb/tb_bpb_gshare.sv
// Directed, scoreboarded bench for bpb_gshare; build with +define+BPB_SPEC_HIST_EN to also
// exercise the speculative history.
module tb_bpb_gshare;
    import mips_pkg::*;

    localparam int PORTS   = 2;
    localparam int IDX_W   = 6;
    localparam int HIST_W  = 4;
    localparam int TAG_W   = 8;
    localparam int ENTRIES = 2**IDX_W;

    logic                   clk = 1'b0;
    logic                   resetn = 1'b0;
    logic                   stall = 1'b0;
    logic [PORTS-1:0][31:0] pc_predict = '0;
    logic                   predict_valid = 1'b0;
    logic [PORTS-1:0]       hit, taken;
    logic [PORTS-1:0][31:0] target;
    logic                   wen = 1'b0;
    logic [31:0]            pc_commit = '0;
    logic                   taken_commit = 1'b0;
    logic [31:0]            target_commit = '0;
    logic                   mispredict = 1'b0;

    always #5 clk = ~clk;

    bpb_gshare #(.PORTS(PORTS), .IDX_W(IDX_W), .HIST_W(HIST_W), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .stall         (stall),
        .pc_predict    (pc_predict),
        .predict_valid (predict_valid),
        .hit           (hit),
        .taken         (taken),
        .target        (target),
        .wen           (wen),
        .pc_commit     (pc_commit),
        .taken_commit  (taken_commit),
        .target_commit (target_commit),
        .mispredict    (mispredict)
    );

    typedef struct packed {
        logic [PORTS-1:0]       hit;
        logic [PORTS-1:0]       taken;
        logic [PORTS-1:0]       tmask;
        logic [PORTS-1:0][31:0] tgt;
    } exp_t;

    exp_t sb [$];
    exp_t last_e;

    logic              m_valid [ENTRIES];
    logic [TAG_W-1:0]  m_tagv  [ENTRIES];
    logic [31:0]       m_tgt   [ENTRIES];
    logic [1:0]        m_ctr   [ENTRIES];
    logic [HIST_W-1:0] m_ghist;
    logic [HIST_W-1:0] m_spec;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [IDX_W-1:0] m_idx(input logic [31:0] pc, input logic [HIST_W-1:0] h);
        return pc[IDX_W+1:2] ^ IDX_W'(h);
    endfunction

    function automatic logic [HIST_W-1:0] look_hist();
`ifdef BPB_SPEC_HIST_EN
        return m_spec;
`else
        return m_ghist;
`endif
    endfunction

    // PC whose index field lands on entry idx under history h.
    function automatic logic [31:0] pc_for(input logic [31:0] base, input logic [IDX_W-1:0] idx,
                                           input logic [HIST_W-1:0] h);
        logic [IDX_W-1:0] f;
        f = idx ^ IDX_W'(h);
        return base | (32'(f) << 2);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 2'b01;
        end
        m_ghist = '0;
        m_spec  = '0;
        sb.delete();
        last_e = '0;
    endtask

    task automatic cycle(input string tag, input logic pv, input logic st, input logic [31:0] pc0,
                         input logic we, input logic [31:0] cpc, input logic ct,
                         input logic [31:0] ctg, input logic mis);
        exp_t e, got;
        logic [HIST_W-1:0] lh, g_new;
        logic [IDX_W-1:0]  li, ci;
        logic [31:0]       pcp;
        @(negedge clk);
        stall = st; predict_valid = pv; wen = we; pc_commit = cpc;
        taken_commit = ct; target_commit = ctg; mispredict = mis;
        for (int p = 0; p < PORTS; p++) pc_predict[p] = pc0 + 32'(4 * p);
        lh = look_hist();
        if (st) e = last_e;
        else begin
            e = '0;
            if (pv) begin
                for (int p = 0; p < PORTS; p++) begin
                    pcp        = pc0 + 32'(4 * p);
                    li         = m_idx(pcp, lh);
                    e.hit[p]   = m_valid[li] && (m_tagv[li] == pcp[IDX_W+TAG_W+1:IDX_W+2]);
                    e.taken[p] = e.hit[p] && m_ctr[li][1];
                    e.tmask[p] = e.hit[p];
                    e.tgt[p]   = m_tgt[li];
                end
            end
        end
        sb.push_back(e);
        last_e = e;
        g_new = m_ghist;
        if (we) begin
            ci = m_idx(cpc, m_ghist);
            if (m_valid[ci] && m_tagv[ci] == cpc[IDX_W+TAG_W+1:IDX_W+2]) begin
                if (ct) m_ctr[ci] = (m_ctr[ci] == 2'b11) ? 2'b11 : m_ctr[ci] + 2'b01;
                else    m_ctr[ci] = (m_ctr[ci] == 2'b00) ? 2'b00 : m_ctr[ci] - 2'b01;
            end else begin
                m_ctr[ci] = ct ? 2'b10 : 2'b01;
            end
            m_valid[ci] = 1'b1;
            m_tagv[ci]  = cpc[IDX_W+TAG_W+1:IDX_W+2];
            m_tgt[ci]   = ctg;
            g_new = {m_ghist[HIST_W-2:0], ct};
        end
        if (we && mis)      m_spec = g_new;
        else if (pv && !st) m_spec = {m_spec[HIST_W-2:0], |e.taken};
        m_ghist = g_new;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({tag, ".hit"},   32'(hit),   32'(got.hit));
        check({tag, ".taken"}, 32'(taken), 32'(got.taken));
        for (int p = 0; p < PORTS; p++)
            if (got.tmask[p]) check($sformatf("%s.target%0d", tag, p), target[p], got.tgt[p]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; predict_valid = 1'b0; wen = 1'b0; stall = 1'b0; mispredict = 1'b0;
        #1;
        check("rst.hit",   32'(hit),   32'h0);
        check("rst.taken", 32'(taken), 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_clear();
    endtask

    logic [1:0] ctr_seq [7];

    initial begin
        ctr_seq = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
        model_clear();
        do_reset();

        cycle("boot", 1'b1, 1'b0, 32'hBFC00000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("boot.hit_c", 32'(hit), 32'h0);

        cycle("alloc", 1'b0, 1'b0, 32'h0, 1'b1, 32'h80000010, 1'b1, 32'h80000100, 1'b0);
        cycle("hit0", 1'b1, 1'b0, pc_for(32'h80000000, 6'd4, look_hist()), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("hit0.hit_c",   32'(hit[0]),   32'h1);
        check("hit0.taken_c", 32'(taken[0]), 32'h1);
        check("hit0.tgt_c",   target[0],     32'h80000100);

        for (int k = 0; k < 7; k++) begin
            cycle("ctr", 1'b0, 1'b0, 32'h0, 1'b1, pc_for(32'h00001200, 6'd20, m_ghist),
                  (k < 4), 32'h1000 + 32'(k), 1'b0);
            check($sformatf("ctr_seq%0d", k), 32'(dut.ctr_q[20]), 32'(ctr_seq[k]));
        end
        cycle("ctr_look", 1'b1, 1'b0, pc_for(32'h00001200, 6'd20, look_hist()), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("ctr_look.hit_c",   32'(hit[0]),   32'h1);
        check("ctr_look.taken_c", 32'(taken[0]), 32'h0);

        cycle("pre_stall", 1'b1, 1'b0, pc_for(32'h80000000, 6'd4, look_hist()), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle("stall", 1'b1, 1'b1, 32'h40000000 + 32'(k * 256), (k == 1),
                  pc_for(32'h00005500, 6'd30, m_ghist), 1'b1, 32'h5500, 1'b0);
`ifdef BPB_SPEC_HIST_EN
            check("stall.spec", 32'(dut.spec_hist_q), 32'(m_spec));
`endif
        end

        cycle("idle", 1'b0, 1'b0, pc_for(32'h80000000, 6'd4, look_hist()), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        cycle("coll", 1'b1, 1'b0, pc_for(32'h00003400, 6'd16, look_hist()), 1'b1,
              pc_for(32'h00003400, 6'd16, m_ghist), 1'b1, 32'h3000, 1'b0);
        check("coll.hit_c", 32'(hit[0]), 32'h0);
        cycle("coll_rep", 1'b1, 1'b0, pc_for(32'h00003400, 6'd16, look_hist()), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("coll_rep.hit_c", 32'(hit[0]), 32'h1);
        check("coll_rep.tgt_c", target[0],   32'h3000);

        for (int k = 0; k < 2; k++) begin
            cycle("pred_t", 1'b1, 1'b0, pc_for(32'h80000000, 6'd4, look_hist()), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            check("pred_t.taken_c", 32'(taken[0]), 32'h1);
        end
        cycle("mis", 1'b0, 1'b0, 32'h0, 1'b1, pc_for(32'h00006600, 6'd40, m_ghist), 1'b0, 32'h6600, 1'b1);
        check("mis.ghist", 32'(dut.ghist_q), 32'(m_ghist));
`ifdef BPB_SPEC_HIST_EN
        check("mis.spec", 32'(dut.spec_hist_q), 32'(m_ghist));
`endif

        @(negedge clk);
        predict_valid = 1'b1; stall = 1'b0; wen = 1'b0;
        pc_predict[0] = pc_for(32'h80000000, 6'd4, look_hist());
        pc_predict[1] = pc_predict[0] + 32'd4;
        #2 resetn = 1'b0;
        #1;
        check("midrst.hit",   32'(hit),   32'h0);
        check("midrst.taken", 32'(taken), 32'h0);
        @(negedge clk);
        resetn = 1'b1; predict_valid = 1'b0;
        model_clear();
        check("midrst.held", 32'(hit), 32'h0);

        cycle("post_alloc", 1'b0, 1'b0, 32'h0, 1'b1, pc_for(32'h00009000, 6'd8, m_ghist), 1'b1, 32'h9100, 1'b0);
        cycle("post_look", 1'b1, 1'b0, pc_for(32'h00009000, 6'd8, look_hist()), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("post_look.hit_c", 32'(hit[0]), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bpb_gshare.md
BPB_GSHARE -- requirements
Module: bpb_gshare

Interface
REQ-001 SHALL have parameter PORTS, default 2: number of parallel prediction ports.
REQ-002 SHALL have parameter IDX_W, default 6: table index width, with 2**IDX_W entries.
REQ-003 SHALL have parameter HIST_W, default 4: global history width, with HIST_W <= IDX_W.
REQ-004 SHALL have parameter TAG_W, default 8: partial tag width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port stall, input, 1 bit: freezes the prediction outputs and speculative history.
REQ-008 SHALL have port pc_predict, input, PORTS x 32 bits: fetch PCs, where port i carries pc+4i.
REQ-009 SHALL have port predict_valid, input, 1 bit: the lookup request is valid.
REQ-010 SHALL have port hit, output, PORTS bits: registered tag-match-and-valid flag per port.
REQ-011 SHALL have port taken, output, PORTS bits: registered counter MSB per port, forced to 0 when there is no hit.
REQ-012 SHALL have port target, output, PORTS x 32 bits: registered stored target per port.
REQ-013 SHALL have ports wen (1 bit), pc_commit (32 bits), taken_commit (1 bit), target_commit (32 bits) and mispredict (1 bit), all inputs, forming the single commit/update port.

Function
REQ-014 SHALL compute index = pc[IDX_W+1:2] XOR zero-extended history, and tag = pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-015 SHALL store, per entry: a valid bit, a tag, a 32-bit target and a 2-bit saturating counter.
REQ-016 SHALL present lookup results one cycle after the request when predict_valid=1 and stall=0.
REQ-017 SHALL hold hit, taken and target unchanged while stall=1.
REQ-018 SHALL clear hit and taken on the next edge when predict_valid=0 and stall=0; target is don't-care in that case.
REQ-019 SHALL, on a commit write (wen=1) to an entry that is valid and tag-matching, increment the counter if taken_commit=1 or decrement it if taken_commit=0, saturating at 2'b11 and 2'b00, and overwrite the target.
REQ-020 SHALL, on a commit write (wen=1) to an entry that misses, allocate it: valid=1, new tag, new target, and counter = 2'b10 if taken, else 2'b01.
REQ-021 SHALL, on the commit path, form the index from the committed history before the shift.
REQ-022 SHALL shift the committed history left on wen=1, inserting taken_commit at bit 0.
REQ-023 SHALL, when a lookup and a commit address the same entry in the same cycle, return the pre-update contents to the lookup.
REQ-024 SHALL treat ports that index the same entry independently, with no arbitration.

Reset
REQ-025 SHALL, while resetn=0: clear all valid bits, set all counters to 2'b01, clear both histories, and drive hit=0 and taken=0.
REQ-026 SHALL abandon any in-flight lookup when reset asserts mid-operation; the first lookup after release completes one cycle after it is issued.

Configuration
REQ-027 SHALL, with BPB_SPEC_HIST_EN defined, keep a speculative history that supplies the lookup index and shifts in the taken bit of the lowest port with hit&taken (or 0 if none) on each lookup with predict_valid=1 and stall=0.
REQ-028 SHALL, with BPB_SPEC_HIST_EN defined and wen&mispredict=1, load the speculative history from the post-shift committed value, overriding any same-cycle speculative shift.
REQ-029 SHALL, without BPB_SPEC_HIST_EN, use the committed history for lookups, ignore mispredict, and contain no speculative register.

Structure
REQ-030 SHALL take the parameter defaults and the bpb_entry_t typedef (valid/tag/target/ctr) from the shared mips package.
REQ-031 SHALL place the 2-bit saturating-counter update logic in one sub-module, bpb_ctr2.

Verification
REQ-032 SHALL cover: after reset, lookup pc=0xBFC00000 -> hit=00, taken=00.
REQ-033 SHALL cover: commit pc=0x80000010, taken, target=0x80000100, then a lookup at the same history -> hit[0]=1, taken[0]=1, target[0]=0x80000100.
REQ-034 SHALL cover: four taken commits then three not-taken commits to one entry at constant index -> counter sequence 10,11,11,11,10,01,00.
REQ-035 SHALL cover: stall=1 held for 3 cycles while pc_predict changes -> outputs unchanged, speculative history unchanged.
REQ-036 SHALL cover: with BPB_SPEC_HIST_EN, two predicted-taken lookups then a mispredict commit -> speculative history equals the committed history.
REQ-037 SHALL cover: a lookup and an allocating commit to the same index in the same cycle -> hit=0 that cycle, hit=1 on a repeat lookup.
